// File: rtl/softmax_exp_combine.sv
// Softmax exponent recombination: scales e^f by a e^-k table to form e^x,
// streams the result, and accumulates the per-vector sum with saturation.
module softmax_exp_combine #(
    parameter int FRAC_BIT = 11,
    parameter int DWIDTH   = 16,
    parameter int SWIDTH   = 24
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_k,
    input  logic [DWIDTH-1:0] in_exp,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_last,
    output logic              sum_valid,
    output logic [SWIDTH-1:0] sum,
    output logic              sum_ovf
);

    localparam int LUT_FRAC  = 15;
    localparam int LUT_W     = 16;
    localparam int PROD_FRAC = FRAC_BIT + LUT_FRAC;
    // Shift the product back from PROD_FRAC to FRAC_BIT fraction bits.
    localparam int SHIFT     = PROD_FRAC - FRAC_BIT;
    localparam int PW        = DWIDTH + LUT_W + 1;
    localparam int AW        = ((SWIDTH > DWIDTH) ? SWIDTH : DWIDTH) + 1;

    localparam logic [PW-1:0] ROUND = {{(PW-1){1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic [AW-1:0] SMAX  = {{(AW-SWIDTH){1'b0}}, {SWIDTH{1'b1}}};

    typedef enum logic {
        IDLE,
        RUN
    } acc_state_t;

    logic              adv;
    logic              hs;
    logic [LUT_W-1:0]  lut_val;

    logic              s1_valid;
    logic [LUT_W-1:0]  s1_lut;
    logic [DWIDTH-1:0] s1_exp;
    logic              s1_last;

    logic              s2_valid;
    logic [DWIDTH-1:0] s2_data;
    logic              s2_last;

    logic [PW-1:0]     prod_full;
    logic [PW-1:0]     prod_rnd;
    logic [DWIDTH-1:0] prod_sat;

    acc_state_t        acc_state;
    acc_state_t        acc_state_next;
    logic [SWIDTH-1:0] acc;
    logic              ovf;
    logic [SWIDTH-1:0] acc_base;
    logic              ovf_base;
    logic [AW-1:0]     total_ext;
    logic              sat_hit;
    logic [SWIDTH-1:0] acc_next;
    logic              ovf_next;

    // A single stall signal freezes both stages whenever S2 holds an unaccepted result.
    assign adv       = out_ready | ~s2_valid;
    assign in_ready  = adv;
    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_last  = s2_last;
    assign hs        = s2_valid & out_ready;

    // e^-k in unsigned Q1.15; beyond k=11 the value rounds to zero.
    always_comb begin
        lut_val = '0;
        case (in_k)
            4'd0:    lut_val = 16'd32768;
            4'd1:    lut_val = 16'd12055;
            4'd2:    lut_val = 16'd4435;
            4'd3:    lut_val = 16'd1631;
            4'd4:    lut_val = 16'd600;
            4'd5:    lut_val = 16'd221;
            4'd6:    lut_val = 16'd81;
            4'd7:    lut_val = 16'd30;
            4'd8:    lut_val = 16'd11;
            4'd9:    lut_val = 16'd4;
            4'd10:   lut_val = 16'd1;
            4'd11:   lut_val = 16'd1;
            default: lut_val = 16'd0;
        endcase
    end

    always_comb begin
        prod_full = PW'(s1_exp) * PW'(s1_lut);
        prod_rnd  = (prod_full + ROUND) >> SHIFT;
        prod_sat  = prod_rnd[DWIDTH-1:0];
        if (|prod_rnd[PW-1:DWIDTH]) begin
            prod_sat = '1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s1_valid <= 1'b0;
            s1_lut   <= '0;
            s1_exp   <= '0;
            s1_last  <= 1'b0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_last  <= 1'b0;
        end else if (clear) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s2_valid <= s1_valid;
            if (in_valid) begin
                s1_lut  <= lut_val;
                s1_exp  <= in_exp;
                s1_last <= in_last;
            end
            if (s1_valid) begin
                s2_data <= prod_sat;
                s2_last <= s1_last;
            end
        end
    end

    // In IDLE the running total starts from zero regardless of the register contents.
    always_comb begin
        acc_state_next = acc_state;
        acc_base       = (acc_state == IDLE) ? '0 : acc;
        ovf_base       = (acc_state == IDLE) ? 1'b0 : ovf;
        total_ext      = AW'(acc_base) + AW'(s2_data);
        sat_hit        = (total_ext > SMAX);
        acc_next       = sat_hit ? {SWIDTH{1'b1}} : total_ext[SWIDTH-1:0];
        ovf_next       = ovf_base | sat_hit;
        if (hs) begin
            acc_state_next = s2_last ? IDLE : RUN;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            acc_state <= IDLE;
            acc       <= '0;
            ovf       <= 1'b0;
            sum_valid <= 1'b0;
            sum       <= '0;
            sum_ovf   <= 1'b0;
        end else if (clear) begin
            acc_state <= IDLE;
            acc       <= '0;
            ovf       <= 1'b0;
            sum_valid <= 1'b0;
        end else begin
            acc_state <= acc_state_next;
            sum_valid <= hs & s2_last;
            if (hs) begin
                if (s2_last) begin
                    acc     <= '0;
                    ovf     <= 1'b0;
                    sum     <= acc_next;
                    sum_ovf <= ovf_next;
                end else begin
                    acc <= acc_next;
                    ovf <= ovf_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_softmax_exp_combine.sv
// Scoreboard bench for softmax_exp_combine: directed vectors with hand-computed
// e^x values and sums, plus a narrow-sum instance for saturation.
module tb_softmax_exp_combine;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } out_item_t;

    typedef struct {
        logic [23:0] total;
        logic        ovf;
    } sum_item_t;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_k;
    logic [15:0] in_exp;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        sum_valid;
    logic [23:0] sum;
    logic        sum_ovf;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [3:0]  b_in_k;
    logic [15:0] b_in_exp;
    logic        b_in_last;
    logic        b_out_valid;
    logic [15:0] b_out_data;
    logic        b_out_last;
    logic        b_sum_valid;
    logic [12:0] b_sum;
    logic        b_sum_ovf;

    out_item_t out_q[$];
    sum_item_t sum_q[$];
    sum_item_t b_sum_q[$];

    int errors = 0;
    int checks = 0;

    softmax_exp_combine dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_k      (in_k),
        .in_exp    (in_exp),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .sum_valid (sum_valid),
        .sum       (sum),
        .sum_ovf   (sum_ovf)
    );

    softmax_exp_combine #(.FRAC_BIT(11), .DWIDTH(16), .SWIDTH(13)) dut_b (
        .clk       (clk),
        .arst_n    (arst_n),
        .clear     (1'b0),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_k      (b_in_k),
        .in_exp    (b_in_exp),
        .in_last   (b_in_last),
        .out_valid (b_out_valid),
        .out_ready (1'b1),
        .out_data  (b_out_data),
        .out_last  (b_out_last),
        .sum_valid (b_sum_valid),
        .sum       (b_sum),
        .sum_ovf   (b_sum_ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushSum(input logic [23:0] total, input logic ovf);
        sum_item_t s;
        s.total = total;
        s.ovf   = ovf;
        sum_q.push_back(s);
    endtask

    // Offers one element and waits (bounded) for acceptance; track=0 leaves it off the scoreboard.
    task automatic applyStimulus(input logic [3:0] k, input logic [15:0] e, input logic last,
                                 input logic [15:0] exp_data, input bit track);
        out_item_t it;
        bit done;
        if (track) begin
            it.data = exp_data;
            it.last = last;
            out_q.push_back(it);
        end
        in_valid = 1'b1;
        in_k     = k;
        in_exp   = e;
        in_last  = last;
        done     = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1");
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic applyB(input logic [3:0] k, input logic [15:0] e, input logic last);
        b_in_valid = 1'b1;
        b_in_k     = k;
        b_in_exp   = e;
        b_in_last  = last;
        @(negedge clk);
        checkOutput("b_in_ready", b_in_ready, 1);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
    endtask

    task automatic waitDrain();
        for (int n = 0; n < 200; n++) begin
            if (out_q.size() == 0 && sum_q.size() == 0 && b_sum_q.size() == 0) break;
            @(negedge clk);
        end
        checkOutput("drain", out_q.size() + sum_q.size() + b_sum_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [15:0] held_data;
    logic        held_last;
    bit          stalled = 1'b0;
    logic [23:0] held_sum = '0;
    logic        held_ovf = 1'b0;

    // Main monitor: output handshakes, stall stability, sum pulses and sum hold.
    always @(negedge clk) begin
        out_item_t it;
        sum_item_t s;
        if (!arst_n) begin
            stalled  = 1'b0;
            held_sum = '0;
            held_ovf = 1'b0;
        end else begin
            if (stalled) begin
                checkOutput("stall_valid", out_valid, 1);
                checkOutput("stall_data", out_data, held_data);
                checkOutput("stall_last", out_last, held_last);
            end
            if (out_valid && !out_ready) begin
                checkOutput("in_ready_stall", in_ready, 0);
                stalled   = 1'b1;
                held_data = out_data;
                held_last = out_last;
            end else begin
                stalled = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (out_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_out: got data %0d, expected no output", out_data);
                end else begin
                    it = out_q.pop_front();
                    checkOutput("out_data", out_data, it.data);
                    checkOutput("out_last", out_last, it.last);
                end
            end
            if (sum_valid) begin
                if (sum_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_sum: got sum %0d, expected no sum_valid", sum);
                end else begin
                    s = sum_q.pop_front();
                    checkOutput("sum", sum, s.total);
                    checkOutput("sum_ovf", sum_ovf, s.ovf);
                    held_sum = s.total;
                    held_ovf = s.ovf;
                end
            end else begin
                checkOutput("sum_hold", sum, held_sum);
                checkOutput("sum_ovf_hold", sum_ovf, held_ovf);
            end
        end
    end

    always @(negedge clk) begin
        sum_item_t s;
        if (arst_n && b_sum_valid) begin
            if (b_sum_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL b_unexpected_sum: got sum %0d, expected no sum_valid", b_sum);
            end else begin
                s = b_sum_q.pop_front();
                checkOutput("b_sum", 32'(b_sum), s.total);
                checkOutput("b_sum_ovf", b_sum_ovf, s.ovf);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        sum_item_t bs;
        arst_n     = 1'b0;
        clear      = 1'b0;
        in_valid   = 1'b0;
        in_k       = '0;
        in_exp     = '0;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        b_in_valid = 1'b0;
        b_in_k     = '0;
        b_in_exp   = '0;
        b_in_last  = 1'b0;

        #12;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_sum_valid", sum_valid, 0);
        checkOutput("rst_sum", sum, 0);
        checkOutput("rst_sum_ovf", sum_ovf, 0);
        @(posedge clk);
        #1 arst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single-element vector: latency and one-cycle sum pulse.
        pushSum(24'd2048, 1'b0);
        applyStimulus(4'd0, 16'd2048, 1'b1, 16'd2048, 1'b1);
        @(negedge clk);
        checkOutput("lat_s1_only", out_valid, 0);
        @(negedge clk);
        checkOutput("lat_out_valid", out_valid, 1);
        @(negedge clk);
        checkOutput("sum_pulse", sum_valid, 1);
        @(negedge clk);
        checkOutput("sum_pulse_width", sum_valid, 0);
        @(posedge clk);
        #1;
        waitDrain();

        pushSum(24'd1030, 1'b0);
        applyStimulus(4'd1,  16'd2048, 1'b0, 16'd753, 1'b1);
        applyStimulus(4'd2,  16'd2048, 1'b0, 16'd277, 1'b1);
        applyStimulus(4'd12, 16'd5567, 1'b1, 16'd0,   1'b1);
        waitDrain();

        // Mixed k with rounding edges and the k=10/11 tail.
        pushSum(24'd89771, 1'b0);
        applyStimulus(4'd3,  16'd2048,  1'b0, 16'd102,   1'b1);
        applyStimulus(4'd1,  16'd65535, 1'b0, 16'd24110, 1'b1);
        applyStimulus(4'd0,  16'd65535, 1'b0, 16'd65535, 1'b1);
        applyStimulus(4'd5,  16'd3000,  1'b0, 16'd20,    1'b1);
        applyStimulus(4'd9,  16'd20000, 1'b0, 16'd2,     1'b1);
        applyStimulus(4'd10, 16'd5000,  1'b0, 16'd0,     1'b1);
        applyStimulus(4'd11, 16'd65535, 1'b1, 16'd2,     1'b1);
        waitDrain();

        pushSum(24'd1000, 1'b0);
        fork
            begin
                applyStimulus(4'd0, 16'd100, 1'b0, 16'd100, 1'b1);
                applyStimulus(4'd0, 16'd200, 1'b0, 16'd200, 1'b1);
                applyStimulus(4'd0, 16'd300, 1'b0, 16'd300, 1'b1);
                applyStimulus(4'd0, 16'd400, 1'b1, 16'd400, 1'b1);
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        waitDrain();

        // Partial sum, then clear while two elements are in flight.
        applyStimulus(4'd0, 16'd500, 1'b0, 16'd500, 1'b1);
        applyStimulus(4'd0, 16'd600, 1'b0, 16'd600, 1'b1);
        waitDrain();
        applyStimulus(4'd0, 16'd700, 1'b0, 16'd0, 1'b0);
        in_valid = 1'b1;
        in_k     = 4'd0;
        in_exp   = 16'd800;
        clear    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("clear_out_valid", out_valid, 0);
            checkOutput("clear_sum_valid", sum_valid, 0);
        end
        @(posedge clk);
        #1;
        pushSum(24'd1753, 1'b0);
        applyStimulus(4'd0, 16'd1000, 1'b0, 16'd1000, 1'b1);
        applyStimulus(4'd1, 16'd2048, 1'b1, 16'd753,  1'b1);
        waitDrain();

        // Reset mid-vector drops the partial sum and the in-flight element.
        applyStimulus(4'd0, 16'd300, 1'b0, 16'd300, 1'b1);
        waitDrain();
        applyStimulus(4'd0, 16'd400, 1'b0, 16'd0, 1'b0);
        arst_n = 1'b0;
        #3;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_in_ready", in_ready, 1);
        checkOutput("midrst_sum", sum, 0);
        @(posedge clk);
        #1 arst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("postrst_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        pushSum(24'd277, 1'b0);
        applyStimulus(4'd2, 16'd2048, 1'b1, 16'd277, 1'b1);
        waitDrain();

        // Back-to-back vectors with no gap after each last.
        pushSum(24'd3072, 1'b0);
        pushSum(24'd4096, 1'b0);
        pushSum(24'd853,  1'b0);
        applyStimulus(4'd0, 16'd1024, 1'b0, 16'd1024, 1'b1);
        applyStimulus(4'd0, 16'd2048, 1'b1, 16'd2048, 1'b1);
        applyStimulus(4'd0, 16'd4096, 1'b1, 16'd4096, 1'b1);
        applyStimulus(4'd1, 16'd2048, 1'b0, 16'd753,  1'b1);
        applyStimulus(4'd0, 16'd100,  1'b1, 16'd100,  1'b1);
        waitDrain();

        // Narrow accumulator saturates, then the next vector starts clean.
        bs.total = 24'd8191;
        bs.ovf   = 1'b1;
        b_sum_q.push_back(bs);
        bs.total = 24'd100;
        bs.ovf   = 1'b0;
        b_sum_q.push_back(bs);
        applyB(4'd0, 16'd4000, 1'b0);
        applyB(4'd0, 16'd4000, 1'b0);
        applyB(4'd0, 16'd4000, 1'b1);
        applyB(4'd0, 16'd100,  1'b1);
        waitDrain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/softmax_exp_combine.md
SOFTMAX_EXP_COMBINE -- requirements
Module: softmax_exp_combine

Interface
REQ-001 SHALL have parameter FRAC_BIT, default 11, giving the fraction bits of in_exp and out_data.
REQ-002 SHALL have parameter DWIDTH, default 16, giving the width of in_exp and out_data.
REQ-003 SHALL have parameter SWIDTH, default 24, giving the width of sum.
REQ-004 clk  input  1  clock; all state on the rising edge.
REQ-005 arst_n  input  1  reset, asynchronous, active-low.
REQ-006 clear  input  1  synchronous flush of the pipeline and the accumulator.
REQ-007 in_valid  input  1  in_k/in_exp/in_last valid.
REQ-008 in_ready  output  1  block accepts input this cycle.
REQ-009 in_k  input  4  integer magnitude k of the reduced exponent x = -k + f, f in [0,1).
REQ-010 in_exp  input  DWIDTH  e^f, unsigned Q5.11, from the piecewise-linear exp stage.
REQ-011 in_last  input  1  final element of the softmax vector.
REQ-012 out_valid / out_ready / out_data[DWIDTH] / out_last  output/input/output/output  e^x stream, unsigned Q5.11.
REQ-013 sum_valid  output  1  one-cycle pulse: the vector sum is on sum.
REQ-014 sum  output  SWIDTH  sum of all out_data in the vector, unsigned Q13.11.
REQ-015 sum_ovf  output  1  qualified by sum_valid: sum saturated in this vector.

Function
REQ-016 SHALL be a 2-stage pipeline: S1 registers LUT(in_k), in_exp and in_last; S2 registers the rounded product and last.
REQ-017 SHALL use a global stall: adv = out_ready | ~S2.valid; in_ready = adv; both stages load only when adv=1.
REQ-018 Input SHALL be accepted on in_valid & in_ready; with no stall, out_valid SHALL rise 2 cycles after acceptance; throughput 1/cycle.
REQ-019 S1.valid SHALL load in_valid when adv=1, so bubbles propagate.
REQ-020 LUT(k) SHALL be unsigned Q1.15, round(32768*e^-k): 32768, 12055, 4435, 1631, 600, 221, 81, 30, 11, 4, 1, 1 for k = 0..11; 0 for k = 12..15.
REQ-021 out_data SHALL be (in_exp*LUT + 2^14) >> 15 from a 32-bit product, saturated to 2^DWIDTH-1.
REQ-022 out_data/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 Accumulator SHALL add out_data on each out handshake (out_valid & out_ready), saturating at 2^SWIDTH-1, and SHALL set a sticky ovf bit on saturation.
REQ-024 Accumulator FSM SHALL have states IDLE (no element of the current vector taken) and RUN. A non-last handshake SHALL move IDLE->RUN. A last handshake from either state SHALL return to IDLE.
REQ-025 On a last handshake, SHALL on the next cycle assert sum_valid for exactly 1 cycle with sum = final total including the last element and sum_ovf = ovf, and SHALL zero the accumulator and ovf in that same update.
REQ-026 sum and sum_ovf SHALL hold their values until the next sum_valid pulse.
REQ-027 A handshake in the cycle after a last (the next vector's first element) SHALL start from 0 and SHALL not corrupt the sum of the previous vector.
REQ-028 clear=1 SHALL zero S1.valid, S2.valid, the accumulator and ovf, SHALL force IDLE and sum_valid=0, and SHALL take priority over every handshake in that cycle; data accepted in that cycle is discarded.

Reset
REQ-029 arst_n=0 SHALL immediately force S1.valid=S2.valid=0, out_valid=0, out_data=0, out_last=0, sum_valid=0, sum=0, sum_ovf=0, accumulator=0, FSM=IDLE; in_ready=1 during and after reset.
REQ-030 Reset mid-vector SHALL drop all in-flight elements and the partial sum with no sum_valid pulse.

Verification
REQ-031 k=0, in_exp=2048, in_last=1, out_ready=1 -> out_data=2048 2 cycles later; sum_valid next cycle, sum=2048, sum_ovf=0.
REQ-032 Vector of (k,exp) = (1,2048), (2,2048), (12,5567, last) -> out_data 753, 277, 0; sum=1030.
REQ-033 Stream 4 elements with out_ready low for 3 cycles mid-stream -> in_ready=0 while S2 is full, out_data stable, no loss or duplication, sum correct.
REQ-034 SWIDTH=13, three elements k=0, exp=4000 -> sum=8191, sum_ovf=1; next vector starts from 0 with sum_ovf=0.
REQ-035 Assert clear (or arst_n) with 2 elements in flight and a partial sum -> no out_valid, no sum_valid; next vector sums correctly.
REQ-036 Back-to-back vectors, last followed immediately by a new first element -> two separate sum_valid pulses with independent correct sums.
